cpu_mem_stage: RTL and testbench

CPU_MEM_STAGE -- requirements
Module: cpu_mem_stage

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/cpu_mem_stage_if.sv | 15 +
 rtl/cpu_mem_busfsm.sv | 106 ++++++++++
 rtl/cpu_mem_stage.sv | 168 ++++++++++++++++
 tb/tb_cpu_mem_stage.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared micro-op encodings, stack type tags and memory-bus FSM state type for the CPU pipeline.
package cpu_pkg;

  localparam logic [1:0] UC_BR_NONE     = 2'd0;
  localparam logic [1:0] UC_BR_REL      = 2'd1;
  localparam logic [1:0] UC_BR_REL_COND = 2'd2;
  localparam logic [1:0] UC_BR_ALU      = 2'd3;

  localparam logic [1:0] UC_MEM_NONE  = 2'd0;
  localparam logic [1:0] UC_MEM_LOAD  = 2'd1;
  localparam logic [1:0] UC_MEM_STORE = 2'd2;

  localparam logic [2:0] UC_PUSH_NONE = 3'd0;
  localparam logic [2:0] UC_PUSH_ALU  = 3'd1;
  localparam logic [2:0] UC_PUSH_IMM  = 3'd2;
  localparam logic [2:0] UC_PUSH_REG0 = 3'd3;
  localparam logic [2:0] UC_PUSH_REG1 = 3'd4;
  localparam logic [2:0] UC_PUSH_MEM  = 3'd5;

  localparam logic [2:0] TYPE_INTEGER = 3'd1;

  // Pop-count encoding meaning "take the count from the ALU result".
  localparam logic [10:0] POP_FROM_ALU = 11'd3;

  typedef enum logic {IDLE, BUSY} bus_state_e;

endpackage

// File: rtl/cpu_mem_stage_if.sv
// Simple request/ack data bus between the memory stage (master) and memory (slave).
interface cpu_mem_stage_if #(
  parameter int DW  = 32,
  parameter int BAW = 8
);
  logic           req;
  logic           we;
  logic [BAW-1:0] addr;
  logic [DW-1:0]  wrdata;
  logic           ack;
  logic [DW-1:0]  rddata;

  modport master (output req, we, addr, wrdata, input ack, rddata);
  modport slave  (input req, we, addr, wrdata, output ack, rddata);
endinterface

// File: rtl/cpu_mem_busfsm.sv
// Bus access FSM: registered req/we/addr/wrdata held from issue until ack; done pulses in the ack cycle.
// Optional CPU_MEM_BUS_TIMEOUT_EN adds a BUSY-cycle counter that ends the access with err after TIMEOUT cycles.
module cpu_mem_busfsm
  import cpu_pkg::*;
#(
  parameter int DW      = 32,
  parameter int BAW     = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start_vld,
  input  logic            is_store,
  input  logic [BAW-1:0]  addr_dat,
  input  logic [DW-1:0]   wrdata_dat,
  cpu_mem_stage_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            err
);

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("cpu_mem_busfsm: TIMEOUT must be at least 1");
  end

  bus_state_e     state_q, state_d;
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [BAW-1:0] addr_q, addr_d;
  logic [DW-1:0]  wrdata_q, wrdata_d;
  logic           timeout;

`ifdef CPU_MEM_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY && !bus.ack) cnt_d = cnt_q + 1'b1;
  end

  // Fires on the TIMEOUT-th BUSY cycle without ack.
  assign timeout = (state_q == BUSY) && !bus.ack && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_vld) begin
          state_d  = BUSY;
          req_d    = 1'b1;
          we_d     = is_store;
          addr_d   = addr_dat;
          wrdata_d = wrdata_dat;
        end
      end
      BUSY: begin
        if (bus.ack || timeout) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          done    = 1'b1;
          err     = timeout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
    end
  end

  assign busy       = (state_q == BUSY);
  assign bus.req    = req_q;
  assign bus.we     = we_q;
  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;

endmodule

// File: rtl/cpu_mem_stage.sv
// CPU memory stage: non-memory ops retire in 1 cycle, memory ops stall stage 3 until bus ack (min 2 cycles).
// Branch/push/pop datapath lives here; bus FSM in cpu_mem_busfsm (timeout via CPU_MEM_BUS_TIMEOUT_EN).
module cpu_mem_stage
  import cpu_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int BAW        = 8,
  parameter int IW         = 48,
  parameter int TW         = 3,
  parameter int ALU_BR_OFS = 6,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             valid_3a,
  input  logic [IW-1:0]    instruction_3a,
  input  logic [AW-1:0]    pc_3a,
  input  logic [DW-1:0]    alu__out_3a,
  input  logic             alu__cond_3a,
  input  logic [1:0]       c__branch_3a,
  input  logic [1:0]       c__mem_3a,
  input  logic [2:0]       c__to_push_3a,
  input  logic [DW+TW-1:0] r0_3a,
  input  logic [DW+TW-1:0] r1_3a,
  input  logic [10:0]      st__to_pop_3a,
  cpu_mem_stage_if.master  bus,
  output logic             stall_3a,
  output logic             valid_4a,
  output logic             kill_4a,
  output logic             bus__err_4a,
  output logic [AW-1:0]    branch_target_4a,
  output logic [AW-1:0]    pc_4a,
  output logic [2:0]       c__to_push_4a,
  output logic [DW+TW-1:0] st__to_push_4a,
  output logic [10:0]      st__to_pop_4a
);

  logic mem_vld, busy, done, bus_err, retire;
  logic br_kill;
  logic [AW-1:0]    br_tgt;
  logic [DW+TW-1:0] push_val;
  logic [10:0]      pop_val;

  logic             valid_4a_q, valid_4a_d;
  logic             kill_4a_q, kill_4a_d;
  logic             err_4a_q, err_4a_d;
  logic [AW-1:0]    tgt_4a_q, tgt_4a_d;
  logic [AW-1:0]    pc_4a_q, pc_4a_d;
  logic [2:0]       push_c_4a_q, push_c_4a_d;
  logic [DW+TW-1:0] push_4a_q, push_4a_d;
  logic [10:0]      pop_4a_q, pop_4a_d;

  logic unused_bits;
  assign unused_bits = ^instruction_3a[IW-1:DW+TW];

  assign mem_vld = valid_3a && (c__mem_3a != UC_MEM_NONE);

  cpu_mem_busfsm #(
    .DW      (DW),
    .BAW     (BAW),
    .TIMEOUT (TIMEOUT)
  ) u_busfsm (
    .clk        (clk),
    .rst_b      (rst_b),
    .start_vld  (mem_vld),
    .is_store   (c__mem_3a == UC_MEM_STORE),
    .addr_dat   (alu__out_3a[BAW-1:0]),
    .wrdata_dat (r0_3a[DW-1:0]),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (bus_err)
  );

  // Stage 3 holds the memory instruction until the ack cycle; stall is forced low in reset.
  assign stall_3a = rst_b && ((!busy && mem_vld) || (busy && !done));
  assign retire   = (valid_3a && (c__mem_3a == UC_MEM_NONE) && !busy) || done;

  always_comb begin
    br_kill = 1'b0;
    br_tgt  = '0;
    case (c__branch_3a)
      UC_BR_REL: begin
        br_kill = 1'b1;
        br_tgt  = pc_3a + {{(AW-16){instruction_3a[15]}}, instruction_3a[15:0]};
      end
      UC_BR_REL_COND: begin
        br_kill = alu__cond_3a;
        br_tgt  = pc_3a + {{(AW-16){instruction_3a[15]}}, instruction_3a[15:0]};
      end
      UC_BR_ALU: begin
        br_kill = 1'b1;
        br_tgt  = AW'(alu__out_3a) + AW'(ALU_BR_OFS);
      end
      default: ;
    endcase
  end

  always_comb begin
    push_val = '0;
    case (c__to_push_3a)
      UC_PUSH_ALU:  push_val = {TW'(TYPE_INTEGER), alu__out_3a};
      UC_PUSH_IMM:  push_val = instruction_3a[DW+TW-1:0];
      UC_PUSH_REG0: push_val = r0_3a;
      UC_PUSH_REG1: push_val = r1_3a;
      UC_PUSH_MEM:  push_val = {TW'(TYPE_INTEGER), bus.rddata};
      default:      push_val = '0;
    endcase
    // A timed-out access pushes a zero integer instead of stale bus data.
    if (bus_err) push_val = {TW'(TYPE_INTEGER), {DW{1'b0}}};
  end

  assign pop_val = (st__to_pop_3a == POP_FROM_ALU) ? alu__out_3a[10:0] : st__to_pop_3a;

  always_comb begin
    valid_4a_d  = 1'b0;
    kill_4a_d   = kill_4a_q;
    err_4a_d    = err_4a_q;
    tgt_4a_d    = tgt_4a_q;
    pc_4a_d     = pc_4a_q;
    push_c_4a_d = push_c_4a_q;
    push_4a_d   = push_4a_q;
    pop_4a_d    = pop_4a_q;
    if (retire) begin
      valid_4a_d  = 1'b1;
      kill_4a_d   = valid_3a && br_kill;
      err_4a_d    = bus_err;
      tgt_4a_d    = br_tgt;
      pc_4a_d     = pc_3a;
      push_c_4a_d = c__to_push_3a;
      push_4a_d   = push_val;
      pop_4a_d    = pop_val;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_4a_q  <= 1'b0;
      kill_4a_q   <= 1'b0;
      err_4a_q    <= 1'b0;
      tgt_4a_q    <= '0;
      pc_4a_q     <= '0;
      push_c_4a_q <= '0;
      push_4a_q   <= '0;
      pop_4a_q    <= '0;
    end else begin
      valid_4a_q  <= valid_4a_d;
      kill_4a_q   <= kill_4a_d;
      err_4a_q    <= err_4a_d;
      tgt_4a_q    <= tgt_4a_d;
      pc_4a_q     <= pc_4a_d;
      push_c_4a_q <= push_c_4a_d;
      push_4a_q   <= push_4a_d;
      pop_4a_q    <= pop_4a_d;
    end
  end

  assign valid_4a         = valid_4a_q;
  assign kill_4a          = kill_4a_q;
  assign bus__err_4a      = err_4a_q;
  assign branch_target_4a = tgt_4a_q;
  assign pc_4a            = pc_4a_q;
  assign c__to_push_4a    = push_c_4a_q;
  assign st__to_push_4a   = push_4a_q;
  assign st__to_pop_4a    = pop_4a_q;

endmodule

// File: tb/tb_cpu_mem_stage.sv
// Directed bench for cpu_mem_stage: vector table for single-cycle ops, hand sequences for bus corner cases.
module tb_cpu_mem_stage;
  import cpu_pkg::*;

  logic        clk, rst_b;
  logic        valid_3a;
  logic [47:0] instruction_3a;
  logic [31:0] pc_3a, alu__out_3a;
  logic        alu__cond_3a;
  logic [1:0]  c__branch_3a, c__mem_3a;
  logic [2:0]  c__to_push_3a;
  logic [34:0] r0_3a, r1_3a;
  logic [10:0] st__to_pop_3a;
  logic        stall_3a, valid_4a, kill_4a, bus__err_4a;
  logic [31:0] branch_target_4a, pc_4a;
  logic [2:0]  c__to_push_4a;
  logic [34:0] st__to_push_4a;
  logic [10:0] st__to_pop_4a;

  cpu_mem_stage_if #(.DW(32), .BAW(8)) bus ();

  cpu_mem_stage #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .valid_3a         (valid_3a),
    .instruction_3a   (instruction_3a),
    .pc_3a            (pc_3a),
    .alu__out_3a      (alu__out_3a),
    .alu__cond_3a     (alu__cond_3a),
    .c__branch_3a     (c__branch_3a),
    .c__mem_3a        (c__mem_3a),
    .c__to_push_3a    (c__to_push_3a),
    .r0_3a            (r0_3a),
    .r1_3a            (r1_3a),
    .st__to_pop_3a    (st__to_pop_3a),
    .bus              (bus),
    .stall_3a         (stall_3a),
    .valid_4a         (valid_4a),
    .kill_4a          (kill_4a),
    .bus__err_4a      (bus__err_4a),
    .branch_target_4a (branch_target_4a),
    .pc_4a            (pc_4a),
    .c__to_push_4a    (c__to_push_4a),
    .st__to_push_4a   (st__to_push_4a),
    .st__to_pop_4a    (st__to_pop_4a)
  );

  typedef struct {
    logic        valid;
    logic [47:0] instr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        cond;
    logic [1:0]  br;
    logic [2:0]  push;
    logic [34:0] r0;
    logic [34:0] r1;
    logic [10:0] pop;
    logic        e_valid;
    logic        e_kill;
    logic [31:0] e_tgt;
    logic        chk_tgt;
    logic [31:0] e_pc;
    logic [2:0]  e_push_c;
    logic [34:0] e_push;
    logic        chk_push;
    logic [10:0] e_pop;
  } vec_t;

  localparam int NV = 7;
  vec_t vec [NV];

  int checks   = 0;
  int failures = 0;
  int stall_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs;
    valid_3a       = 1'b0;
    instruction_3a = '0;
    pc_3a          = '0;
    alu__out_3a    = '0;
    alu__cond_3a   = 1'b0;
    c__branch_3a   = UC_BR_NONE;
    c__mem_3a      = UC_MEM_NONE;
    c__to_push_3a  = UC_PUSH_NONE;
    r0_3a          = '0;
    r1_3a          = '0;
    st__to_pop_3a  = '0;
  endtask

  task automatic mem_op(input logic [1:0] mem, input logic [31:0] addr, input logic [34:0] r0);
    idle_inputs();
    valid_3a      = 1'b1;
    c__mem_3a     = mem;
    alu__out_3a   = addr;
    r0_3a         = r0;
    c__to_push_3a = (mem == UC_MEM_LOAD) ? UC_PUSH_MEM : UC_PUSH_NONE;
  endtask

  initial begin
    vec[0] = '{1'b1, 48'h0000_0000_FFF0, 32'h100, 32'h0, 1'b0, UC_BR_REL, UC_PUSH_NONE, 35'h0, 35'h0, 11'd0,
               1'b1, 1'b1, 32'h0F0, 1'b1, 32'h100, UC_PUSH_NONE, 35'h0, 1'b0, 11'd0};
    vec[1] = '{1'b1, 48'h0, 32'h104, 32'h40, 1'b0, UC_BR_ALU, UC_PUSH_ALU, 35'h0, 35'h0, 11'd5,
               1'b1, 1'b1, 32'h46, 1'b1, 32'h104, UC_PUSH_ALU, 35'h1_0000_0040, 1'b1, 11'd5};
    vec[2] = '{1'b1, 48'hABC4_1234_0010, 32'h200, 32'h7FF, 1'b0, UC_BR_REL_COND, UC_PUSH_IMM, 35'h0, 35'h0, 11'd3,
               1'b1, 1'b0, 32'h210, 1'b1, 32'h200, UC_PUSH_IMM, 35'h4_1234_0010, 1'b1, 11'h7FF};
    vec[3] = '{1'b1, 48'h0000_0000_8000, 32'h300, 32'hC0A, 1'b1, UC_BR_REL_COND, UC_PUSH_REG0, 35'h5_1111_2222, 35'h0, 11'd3,
               1'b1, 1'b1, 32'hFFFF_8300, 1'b1, 32'h300, UC_PUSH_REG0, 35'h5_1111_2222, 1'b1, 11'h40A};
    vec[4] = '{1'b1, 48'h0, 32'h400, 32'h0, 1'b1, UC_BR_NONE, UC_PUSH_REG1, 35'h0, 35'h2_ABCD_EF01, 11'd2,
               1'b1, 1'b0, 32'h0, 1'b0, 32'h400, UC_PUSH_REG1, 35'h2_ABCD_EF01, 1'b1, 11'd2};
    vec[5] = '{1'b0, 48'h0000_0000_0004, 32'h500, 32'h99, 1'b1, UC_BR_REL, UC_PUSH_ALU, 35'h7, 35'h9, 11'd7,
               1'b0, 1'b0, 32'h0, 1'b0, 32'h400, UC_PUSH_REG1, 35'h2_ABCD_EF01, 1'b1, 11'd2};
    vec[6] = '{1'b1, 48'h0, 32'h600, 32'hFFFF_FFFC, 1'b0, UC_BR_ALU, UC_PUSH_NONE, 35'h0, 35'h0, 11'd0,
               1'b1, 1'b1, 32'h2, 1'b1, 32'h600, UC_PUSH_NONE, 35'h0, 1'b0, 11'd0};

    idle_inputs();
    bus.ack    = 1'b0;
    bus.rddata = '0;
    rst_b      = 1'b1;
    #2 rst_b = 1'b0;
    valid_3a  = 1'b1;
    c__mem_3a = UC_MEM_LOAD;
    #1;
    chk("rst_stall", 64'(stall_3a), 64'(0));
    chk("rst_req", 64'(bus.req), 64'(0));
    chk("rst_valid", 64'(valid_4a), 64'(0));
    chk("rst_kill", 64'(kill_4a), 64'(0));
    chk("rst_err", 64'(bus__err_4a), 64'(0));
    chk("rst_tgt", 64'(branch_target_4a), 64'(0));
    chk("rst_pc", 64'(pc_4a), 64'(0));
    chk("rst_push", 64'(st__to_push_4a), 64'(0));
    chk("rst_pop", 64'(st__to_pop_4a), 64'(0));
    tick();
    tick();
    chk("rst_req_clk", 64'(bus.req), 64'(0));
    idle_inputs();
    rst_b = 1'b1;
    tick();

    // Single-cycle retirement table.
    for (int i = 0; i < NV; i++) begin
      valid_3a       = vec[i].valid;
      instruction_3a = vec[i].instr;
      pc_3a          = vec[i].pc;
      alu__out_3a    = vec[i].alu;
      alu__cond_3a   = vec[i].cond;
      c__branch_3a   = vec[i].br;
      c__to_push_3a  = vec[i].push;
      r0_3a          = vec[i].r0;
      r1_3a          = vec[i].r1;
      st__to_pop_3a  = vec[i].pop;
      #1;
      chk($sformatf("v%0d_stall", i), 64'(stall_3a), 64'(0));
      tick();
      chk($sformatf("v%0d_valid", i), 64'(valid_4a), 64'(vec[i].e_valid));
      chk($sformatf("v%0d_kill", i), 64'(kill_4a), 64'(vec[i].e_kill));
      chk($sformatf("v%0d_pc", i), 64'(pc_4a), 64'(vec[i].e_pc));
      chk($sformatf("v%0d_push_c", i), 64'(c__to_push_4a), 64'(vec[i].e_push_c));
      chk($sformatf("v%0d_pop", i), 64'(st__to_pop_4a), 64'(vec[i].e_pop));
      if (vec[i].chk_tgt) chk($sformatf("v%0d_tgt", i), 64'(branch_target_4a), 64'(vec[i].e_tgt));
      if (vec[i].chk_push) chk($sformatf("v%0d_push", i), 64'(st__to_push_4a), 64'(vec[i].e_push));
    end

    // LOAD with ack three cycles after req.
    mem_op(UC_MEM_LOAD, 32'h12, 35'h0);
    #1;
    stall_cnt = 0;
    if (stall_3a) stall_cnt++;
    chk("ld_req_pre", 64'(bus.req), 64'(0));
    for (int c = 1; c < 4; c++) begin
      tick();
      if (stall_3a) stall_cnt++;
      chk($sformatf("ld_req_c%0d", c), 64'(bus.req), 64'(1));
      chk($sformatf("ld_addr_c%0d", c), 64'(bus.addr), 64'(8'h12));
    end
    chk("ld_we", 64'(bus.we), 64'(0));
    tick();
    bus.ack    = 1'b1;
    bus.rddata = 32'hDEAD_BEEF;
    #1;
    if (stall_3a) stall_cnt++;
    chk("ld_stall_ack", 64'(stall_3a), 64'(0));
    chk("ld_valid_ack", 64'(valid_4a), 64'(0));
    tick();
    bus.ack = 1'b0;
    idle_inputs();
    chk("ld_stall_cnt", 64'(stall_cnt), 64'(4));
    chk("ld_valid", 64'(valid_4a), 64'(1));
    chk("ld_push", 64'(st__to_push_4a), 64'(35'h1_DEAD_BEEF));
    chk("ld_push_c", 64'(c__to_push_4a), 64'(UC_PUSH_MEM));
    chk("ld_err", 64'(bus__err_4a), 64'(0));
    chk("ld_req_end", 64'(bus.req), 64'(0));

    // STORE acked on the first BUSY cycle.
    mem_op(UC_MEM_STORE, 32'h34, 35'h55);
    #1;
    chk("st_stall_issue", 64'(stall_3a), 64'(1));
    tick();
    chk("st_req", 64'(bus.req), 64'(1));
    chk("st_we", 64'(bus.we), 64'(1));
    chk("st_wrdata", 64'(bus.wrdata), 64'(32'h55));
    chk("st_addr", 64'(bus.addr), 64'(8'h34));
    chk("st_valid_busy", 64'(valid_4a), 64'(0));
    bus.ack = 1'b1;
    #1;
    chk("st_stall_ack", 64'(stall_3a), 64'(0));
    tick();
    bus.ack = 1'b0;
    idle_inputs();
    chk("st_valid", 64'(valid_4a), 64'(1));
    chk("st_req_end", 64'(bus.req), 64'(0));

    // Back-to-back loads must each see a full IDLE->BUSY->IDLE round.
    mem_op(UC_MEM_LOAD, 32'h20, 35'h0);
    #1;
    tick();
    chk("b2b_req_a", 64'(bus.req), 64'(1));
    chk("b2b_addr_a", 64'(bus.addr), 64'(8'h20));
    bus.ack    = 1'b1;
    bus.rddata = 32'h1111;
    #1;
    tick();
    bus.ack     = 1'b0;
    alu__out_3a = 32'h21;
    #1;
    chk("b2b_valid_a", 64'(valid_4a), 64'(1));
    chk("b2b_push_a", 64'(st__to_push_4a), 64'(35'h1_0000_1111));
    chk("b2b_req_gap", 64'(bus.req), 64'(0));
    chk("b2b_stall_gap", 64'(stall_3a), 64'(1));
    tick();
    chk("b2b_req_b", 64'(bus.req), 64'(1));
    chk("b2b_addr_b", 64'(bus.addr), 64'(8'h21));
    chk("b2b_valid_busy", 64'(valid_4a), 64'(0));
    bus.ack    = 1'b1;
    bus.rddata = 32'h2222;
    #1;
    tick();
    bus.ack = 1'b0;
    idle_inputs();
    chk("b2b_valid_b", 64'(valid_4a), 64'(1));
    chk("b2b_push_b", 64'(st__to_push_4a), 64'(35'h1_0000_2222));

    // Spurious ack while IDLE.
    bus.ack    = 1'b1;
    bus.rddata = 32'hBAD;
    tick();
    tick();
    chk("spur_valid", 64'(valid_4a), 64'(0));
    chk("spur_req", 64'(bus.req), 64'(0));
    chk("spur_push_hold", 64'(st__to_push_4a), 64'(35'h1_0000_2222));
    bus.ack = 1'b0;

    // Reset asserted mid-BUSY aborts the access.
    mem_op(UC_MEM_LOAD, 32'h30, 35'h0);
    #1;
    tick();
    chk("rb_req_busy", 64'(bus.req), 64'(1));
    rst_b = 1'b0;
    #1;
    chk("rb_req", 64'(bus.req), 64'(0));
    chk("rb_stall", 64'(stall_3a), 64'(0));
    chk("rb_valid", 64'(valid_4a), 64'(0));
    chk("rb_push", 64'(st__to_push_4a), 64'(0));
    tick();
    idle_inputs();
    rst_b = 1'b1;
    tick();
    chk("rb_valid_after", 64'(valid_4a), 64'(0));
    chk("rb_req_after", 64'(bus.req), 64'(0));

    // Access with no ack.
    mem_op(UC_MEM_LOAD, 32'h40, 35'h0);
    #1;
`ifdef CPU_MEM_BUS_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("to_req_c%0d", c), 64'(bus.req), 64'(1));
      chk($sformatf("to_stall_c%0d", c), 64'(stall_3a), 64'(c < 4));
    end
    tick();
    idle_inputs();
    chk("to_valid", 64'(valid_4a), 64'(1));
    chk("to_err", 64'(bus__err_4a), 64'(1));
    chk("to_push", 64'(st__to_push_4a), 64'(35'h1_0000_0000));
    chk("to_req_end", 64'(bus.req), 64'(0));
`else
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("na_stall_c%0d", c), 64'(stall_3a), 64'(1));
      chk($sformatf("na_req_c%0d", c), 64'(bus.req), 64'(1));
    end
    bus.ack    = 1'b1;
    bus.rddata = 32'h0BAD_F00D;
    #1;
    chk("na_stall_ack", 64'(stall_3a), 64'(0));
    tick();
    bus.ack = 1'b0;
    idle_inputs();
    chk("na_valid", 64'(valid_4a), 64'(1));
    chk("na_err", 64'(bus__err_4a), 64'(0));
    chk("na_push", 64'(st__to_push_4a), 64'(35'h1_0BAD_F00D));
`endif
    tick();
    chk("end_valid", 64'(valid_4a), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
